// File: rtl/mux81_scan_ctrl.sv
// Scan sequencer for an 8:1 bit mux: steps the select, samples y after HOLD_CYCLES
// cycles per index, and presents the assembled byte on a valid/ready port.
module mux81_scan_ctrl #(
  parameter int HOLD_CYCLES = 1,
  parameter bit DESCENDING  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic [2:0] s,
  output logic       busy,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready
);

  // state | meaning
  // IDLE  | waiting for start, select parked at 0
  // SCAN  | stepping select, sampling y once per hold window
  // OUT   | captured word held on data until valid && ready
  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  localparam int          HW        = 5;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]  FIRST_IDX = DESCENDING ? 3'd7 : 3'd0;
  localparam logic [2:0]  LAST_IDX  = DESCENDING ? 3'd0 : 3'd7;

  state_t          state, state_nxt;
  logic [HW-1:0]   hold_cnt;
  logic [2:0]      idx;
  logic [7:0]      shadow, shadow_upd, data_q;
  logic            sample, last_sample;

  assign sample      = (state == SCAN) && (hold_cnt == HOLD_LAST);
  assign last_sample = sample && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_sample) state_nxt = OUT;
      OUT:     if (ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Final bit merged combinationally so data gets the complete word on the last sampling edge
  always_comb begin
    shadow_upd      = shadow;
    shadow_upd[idx] = y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      idx      <= '0;
      shadow   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          idx      <= FIRST_IDX;
        end
        SCAN: begin
          if (sample) begin
            shadow   <= shadow_upd;
            hold_cnt <= '0;
            if (idx == LAST_IDX) data_q <= shadow_upd;
            else if (DESCENDING) idx <= idx - 3'd1;
            else                 idx <= idx + 3'd1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign s     = (state == SCAN) ? idx : 3'd0;
  assign busy  = (state != IDLE);
  assign valid = (state == OUT);
  assign data  = data_q;

endmodule

// File: tb/tb_mux81_scan_ctrl.sv
// Bench for mux81_scan_ctrl: two instances (ascending/1-cycle hold and descending/3-cycle hold)
// share stimulus and are compared every cycle against a cycle-count reference model.
module tb_mux81_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic [7:0] din;
  logic       y0, y1;
  logic [2:0] s0, s1;
  logic       busy0, busy1, valid0, valid1;
  logic [7:0] data0, data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux81_scan_ctrl #(.HOLD_CYCLES(1), .DESCENDING(1'b0)) u_asc (
    .clk(clk), .rst(rst), .start(start), .y(y0), .s(s0),
    .busy(busy0), .data(data0), .valid(valid0), .ready(ready));

  mux81_scan_ctrl #(.HOLD_CYCLES(3), .DESCENDING(1'b1)) u_desc (
    .clk(clk), .rst(rst), .start(start), .y(y1), .s(s1),
    .busy(busy1), .data(data1), .valid(valid1), .ready(ready));

  // Behavioural 8:1 muxes
  assign y0 = din[s0];
  assign y1 = din[s1];

  // Reference model: mode 0=idle 1=scanning 2=output; t = cycles since the start edge
  int         hc[2]  = '{1, 3};
  bit         dsc[2] = '{1'b0, 1'b1};
  int         m_mode[2];
  int         m_t[2];
  logic [7:0] m_cap[2];
  logic [7:0] m_data[2];

  function automatic int ord(int i, int k);
    return dsc[i] ? 7 - k : k;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = 0;
        m_t[i]    = 0;
        m_data[i] = 8'h00;
      end else begin
        case (m_mode[i])
          0: if (start) begin m_mode[i] = 1; m_t[i] = 0; end
          1: begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] % hc[i] == 0) begin
              m_cap[i][ord(i, m_t[i] / hc[i] - 1)] = din[ord(i, m_t[i] / hc[i] - 1)];
              if (m_t[i] == 8 * hc[i]) begin
                m_data[i] = m_cap[i];
                m_mode[i] = 2;
              end
            end
          end
          default: if (ready) m_mode[i] = 0;
        endcase
      end
    end
  end

  function automatic logic [2:0] exp_s(int i);
    return (m_mode[i] == 1) ? 3'(ord(i, m_t[i] / hc[i])) : 3'd0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_val("s_asc",      32'(s0),     32'(exp_s(0)));
    check_val("busy_asc",   32'(busy0),  32'(m_mode[0] != 0));
    check_val("valid_asc",  32'(valid0), 32'(m_mode[0] == 2));
    check_val("data_asc",   32'(data0),  32'(m_data[0]));
    check_val("s_desc",     32'(s1),     32'(exp_s(1)));
    check_val("busy_desc",  32'(busy1),  32'(m_mode[1] != 0));
    check_val("valid_desc", 32'(valid1), 32'(m_mode[1] == 2));
    check_val("data_desc",  32'(data1),  32'(m_data[1]));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int lat0, lat1, b0, b1, rise1, rise2, n;
  logic [7:0] d0, d1;
  logic prev_busy;
  bit found;

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1; din = 8'h00;
    steps(2);
    check_val("reset_data", 32'(data0), 32'h0);
    check_val("reset_s",    32'(s1),    32'h0);
    rst = 1'b0;
    steps(2);

    // Basic scan, both orders
    din = 8'b1010_0110; start = 1'b1;
    step();
    start = 1'b0;
    lat0 = -1; lat1 = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (valid0 && lat0 < 0) begin lat0 = k; d0 = data0; end
      if (valid1 && lat1 < 0) begin lat1 = k; d1 = data1; end
    end
    check_val("lat_asc",   32'(lat0), 32'd8);
    check_val("lat_desc",  32'(lat1), 32'd24);
    check_val("word_asc",  32'(d0),   32'hA6);
    check_val("word_desc", 32'(d1),   32'hA6);

    // Backpressure with a start pulse during OUT
    ready = 1'b0; din = 8'h5A; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      found = valid0 && valid1;
    end
    check_val("bp_wait", 32'(found), 32'd1);
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      step();
    end
    start = 1'b0;
    check_val("bp_valid", 32'(valid0), 32'd1);
    check_val("bp_data",  32'(data1),  32'h5A);
    check_val("bp_busy",  32'(busy0),  32'd1);
    ready = 1'b1;
    steps(3);
    check_val("bp_idle", 32'(busy0 | busy1), 32'd0);

    // Reset mid-scan
    din = 8'hC3; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      found = (s0 == 3'd4);
    end
    check_val("rst_wait", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst_s",     32'(s0),             32'd0);
    check_val("rst_busy",  32'(busy0 | busy1),  32'd0);
    check_val("rst_valid", 32'(valid0 | valid1), 32'd0);
    check_val("rst_data",  32'(data0),          32'h00);
    din = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    steps(30);
    check_val("post_rst_asc",  32'(data0), 32'h3C);
    check_val("post_rst_desc", 32'(data1), 32'h3C);

    // Back-to-back with start held high
    rst = 1'b1; step(); rst = 1'b0;
    din = 8'hFF; start = 1'b1;
    prev_busy = 1'b0; rise1 = -1; rise2 = -1; b0 = 0;
    for (int k = 0; k < 40 && rise2 < 0; k++) begin
      step();
      if (busy0 && !prev_busy) begin
        if (rise1 < 0) rise1 = k; else rise2 = k;
      end
      if (valid0 && b0 == 0) begin
        b0 = 1;
        check_val("b2b_first", 32'(data0), 32'hFF);
        din = 8'h01;
      end
      prev_busy = busy0;
    end
    check_val("b2b_period", 32'(rise2 - rise1), 32'd10);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      found = valid0;
    end
    check_val("b2b_wait",   32'(found), 32'd1);
    check_val("b2b_second", 32'(data0), 32'h01);
    start = 1'b0;

    // Mid-scan change of i7
    rst = 1'b1; step(); rst = 1'b0; ready = 1'b1;
    din = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (s0 == 3'd3) din[7] = 1'b1;
      if (s0 == 3'd5) din[7] = 1'b0;
      if (s0 == 3'd6) din[7] = 1'b1;
      step();
    end
    check_val("i7_capture", 32'(data0), 32'h80);

    // Randomized traffic
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      din   = 8'($urandom);
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
